riscv_alu_mul_seq: RTL and testbench
====================================

RISCV_ALU_MUL_SEQ -- requirements
Module: riscv_alu_mul_seq

Interface
REQ-001 The block SHALL have no parameters; operand and result width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 abort  input  1  synchronous cancel of the operation in progress.
REQ-006 op_a  input  32  multiplicand, captured on the accepted start.
REQ-007 op_b  input  32  multiplier, captured on the accepted start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse, high only in DONE.
REQ-010 product  output  32  low 32 bits of op_a*op_b (unsigned), registered.
REQ-011 SrcA  output  32  ALU operand A, driven to the shared ALU.
REQ-012 SrcB  output  32  ALU operand B, driven to the shared ALU.
REQ-013 ALUControl  output  3  ALU opcode (000 add, 001 shl, 101 shr).
REQ-014 ALUResult  input  32  combinational ALU result for the current cycle.
REQ-015 Zero_flag  input  1  ALU zero flag for the current cycle; the block SHALL NOT use Sign_flag.

Function
REQ-016 The state machine SHALL have the states IDLE, ADD, SHL, SHR and DONE; each non-IDLE state SHALL last exactly one cycle.
REQ-017 In IDLE with start=1 and abort=0, the block SHALL load a<=op_a, b<=op_b, acc<=0 and iter<=0 (5-bit counter).
REQ-018 On that start, the next state SHALL be DONE if op_b==0, ADD if op_b[0]==1, and SHL otherwise.
REQ-019 ADD SHALL drive ALUControl=000, SrcA=acc and SrcB=a, load acc<=ALUResult and go to SHL.
REQ-020 SHL SHALL drive ALUControl=001, SrcA=a and SrcB=1, load a<=ALUResult and go to SHR.
REQ-021 SHR SHALL drive ALUControl=101, SrcA=b and SrcB=1, load b<=ALUResult and increment iter.
REQ-022 From SHR, the next state SHALL be DONE if Zero_flag==1 or iter==31 before the increment; otherwise it SHALL be ADD if ALUResult[0]==1, else SHL.
REQ-023 On entry to DONE, product SHALL take the final acc; in DONE, done SHALL be 1 and the next state SHALL be IDLE.
REQ-024 product SHALL hold its value until the next DONE; intermediate acc values SHALL never appear on product.
REQ-025 In IDLE and DONE, the block SHALL drive ALUControl=000, SrcA=0 and SrcB=0.
REQ-026 All arithmetic SHALL wrap modulo 2^32; overflow SHALL NOT be flagged.
REQ-027 Latency from the start edge to done high SHALL be 1 + (2 x number of SHR iterations) + (number of 1 bits in op_b) cycles, with iterations ending at the highest set bit of op_b.
REQ-028 start asserted while busy=1, including in DONE, SHALL be ignored and SHALL NOT be queued.
REQ-029 abort=1 in any state SHALL force the next state to IDLE with no done pulse and product unchanged.
REQ-030 abort=1 together with start=1 in IDLE SHALL take priority; the start SHALL NOT be accepted.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0 and product=0, with no dependence on clk.
REQ-032 While rst_n=0, the block SHALL immediately force a, b, acc and iter to 0, and ALUControl, SrcA and SrcB to 0.
REQ-033 Reset asserted mid-operation SHALL discard the operation; after release, the block SHALL accept a new start on the first rising edge.

Verification
REQ-034 Bench SHALL cover: op_a=3, op_b=5 -> sequence ADD,SHL,SHR,SHL,SHR,ADD,SHL,SHR, then done in the 9th cycle after the start edge with product=15.
REQ-035 Bench SHALL cover: op_a=0x1234, op_b=0 -> done in the 1st cycle after start with product=0 and no ALU ops issued.
REQ-036 Bench SHALL cover: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> 32 iterations, done after 97 cycles, product=0x00000001.
REQ-037 Bench SHALL cover: op_a=7, op_b=6, with a second start (op_a=9, op_b=9) two cycles later -> the second start is ignored and product=42.
REQ-038 Bench SHALL cover: abort asserted in SHL of 3x5 -> IDLE next cycle, no done pulse, product keeps its prior value; a following 2x4 start -> product=8.
REQ-039 Bench SHALL cover: rst_n pulsed low mid-operation between clock edges -> busy=0 and product=0 immediately, with no done pulse.

Source files
------------

// File: rtl/riscv_alu_mul_seq_if.sv
// Bus between the sequential multiplier and its surroundings: the requester handshake
// plus the shared-ALU operand/result path. The "master" side is the requester together with the ALU.
interface riscv_alu_mul_seq_if;
    logic        start;
    logic        abort;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero_flag;
    logic [2:0]  state_dbg;

    modport slave (
        input  start, abort, op_a, op_b, ALUResult, Zero_flag,
        output busy, done, product, SrcA, SrcB, ALUControl, state_dbg
    );

    modport master (
        output start, abort, op_a, op_b, ALUResult, Zero_flag,
        input  busy, done, product, SrcA, SrcB, ALUControl, state_dbg
    );
endinterface

// File: rtl/riscv_alu_mul_seq.sv
// Shift-and-add 32x32 -> low-32 unsigned multiplier that borrows a shared external ALU
// for every add and shift; one ALU operation per cycle.
module riscv_alu_mul_seq (
    input  logic                       clk,
    input  logic                       rst_n,
    riscv_alu_mul_seq_if.slave         bus
);
    // Handshake: start is accepted only in IDLE with abort low; busy is high outside IDLE;
    // done is a one-cycle pulse in DONE with product already valid; abort wins over everything.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADD  = 3'd1,
        S_SHL  = 3'd2,
        S_SHR  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;
    localparam logic [2:0] ALU_SHR = 3'b101;

    state_e      state, next_state;
    logic [31:0] a_q, b_q, acc_q, product_q;
    logic [4:0]  iter_q;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctl;
    logic        accept;

    assign accept = (state == S_IDLE) && bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_ctl    = ALU_ADD;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op_b == 32'd0) next_state = S_DONE;
                    else if (bus.op_b[0])  next_state = S_ADD;
                    else                   next_state = S_SHL;
                end
            end
            S_ADD: begin
                alu_a      = acc_q;
                alu_b      = a_q;
                next_state = S_SHL;
            end
            S_SHL: begin
                alu_ctl    = ALU_SHL;
                alu_a      = a_q;
                alu_b      = 32'd1;
                next_state = S_SHR;
            end
            S_SHR: begin
                alu_ctl = ALU_SHR;
                alu_a   = b_q;
                alu_b   = 32'd1;
                // Remaining multiplier bits gone (or all 32 consumed): nothing left to add.
                if (bus.Zero_flag || iter_q == 5'd31) next_state = S_DONE;
                else if (bus.ALUResult[0])            next_state = S_ADD;
                else                                  next_state = S_SHL;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (bus.abort) next_state = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            iter_q    <= '0;
            product_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_q    <= bus.op_a;
                        b_q    <= bus.op_b;
                        acc_q  <= '0;
                        iter_q <= '0;
                    end
                end
                S_ADD: acc_q <= bus.ALUResult;
                S_SHL: a_q   <= bus.ALUResult;
                S_SHR: begin
                    b_q    <= bus.ALUResult;
                    iter_q <= iter_q + 5'd1;
                end
                default: ;
            endcase
            // Only the final accumulator is published; a zero multiplier goes straight from IDLE.
            if (next_state == S_DONE && state != S_DONE)
                product_q <= (state == S_IDLE) ? 32'd0 : acc_q;
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.product    = product_q;
    assign bus.SrcA       = alu_a;
    assign bus.SrcB       = alu_b;
    assign bus.ALUControl = alu_ctl;
    assign bus.state_dbg  = state;
endmodule

// File: tb/tb_riscv_alu_mul_seq.sv
// Bench for riscv_alu_mul_seq: models the shared ALU, and predicts the ALU operation
// stream, latency and product from the shift-and-add definition of multiplication.
module tb_riscv_alu_mul_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_bad;
    logic [31:0] alu_r;

    logic [31:0] exp_ctl_q[$];
    logic [31:0] exp_srca_q[$];
    logic [31:0] exp_srcb_q[$];

    riscv_alu_mul_seq_if bus ();

    riscv_alu_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // shared ALU
    always_comb begin
        alu_r = '0;
        case (bus.ALUControl)
            3'b000:  alu_r = bus.SrcA + bus.SrcB;
            3'b001:  alu_r = bus.SrcA << bus.SrcB[4:0];
            3'b101:  alu_r = bus.SrcA >> bus.SrcB[4:0];
            default: alu_r = '0;
        endcase
    end
    assign bus.ALUResult = alu_r;
    assign bus.Zero_flag = (alu_r == 32'd0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on a falling edge; issues one multiply and follows it to IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int extra_at);
        logic [31:0] acc_m;
        logic [31:0] prod_m;
        logic [31:0] exp_lat;
        int          cyc;
        exp_ctl_q.delete();
        exp_srca_q.delete();
        exp_srcb_q.delete();
        acc_m  = '0;
        prod_m = a * b;
        for (int i = 0; i < 32; i++) begin
            if ((b >> i) != 32'd0) begin
                if (b[i]) begin
                    exp_ctl_q.push_back(32'd0);
                    exp_srca_q.push_back(acc_m);
                    exp_srcb_q.push_back(a << i);
                    acc_m = acc_m + (a << i);
                end
                exp_ctl_q.push_back(32'd1);
                exp_srca_q.push_back(a << i);
                exp_srcb_q.push_back(32'd1);
                exp_ctl_q.push_back(32'd5);
                exp_srca_q.push_back(b >> i);
                exp_srcb_q.push_back(32'd1);
            end
        end
        exp_lat = exp_ctl_q.size() + 1;

        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.done) begin
                if (cyc == extra_at) begin
                    bus.start = 1'b1;
                    bus.op_a  = 32'd9;
                    bus.op_b  = 32'd9;
                end
                break;
            end
            check("busy", bus.busy, 32'd1);
            if (exp_ctl_q.size() != 0) begin
                check("alu_ctl", bus.ALUControl, exp_ctl_q.pop_front());
                check("alu_srca", bus.SrcA, exp_srca_q.pop_front());
                check("alu_srcb", bus.SrcB, exp_srcb_q.pop_front());
            end
            if (cyc == extra_at) begin
                bus.start = 1'b1;
                bus.op_a  = 32'd9;
                bus.op_b  = 32'd9;
            end
        end
        check("latency", cyc, exp_lat);
        check("product", bus.product, prod_m);
        check("done_ctl", bus.ALUControl, 32'd0);
        check("done_srca", bus.SrcA, 32'd0);
        check("done_srcb", bus.SrcB, 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        check("done_pulse", bus.done, 32'd0);
        check("idle_busy", bus.busy, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        n_checks  = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        #12;
        check("rst_busy", bus.busy, 32'd0);
        check("rst_done", bus.done, 32'd0);
        check("rst_product", bus.product, 32'd0);
        check("rst_ctl", bus.ALUControl, 32'd0);
        check("rst_srca", bus.SrcA, 32'd0);
        check("rst_srcb", bus.SrcB, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'd3, 32'd5, -1);
        run_op(32'h1234, 32'd0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(32'd7, 32'd6, 1);

        // abort while in SHL of 3x5
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_add", bus.ALUControl, 32'd0);
        @(negedge clk);
        check("abort_shl", bus.ALUControl, 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 32'd0);
        check("abort_done", bus.done, 32'd0);
        check("abort_product", bus.product, 32'd42);
        run_op(32'd2, 32'd4, -1);

        // abort together with start in IDLE
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_start_busy", bus.busy, 32'd0);
        check("abort_start_product", bus.product, 32'd8);

        // reset pulsed between edges mid-operation
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 32'd0);
        check("mid_rst_done", bus.done, 32'd0);
        check("mid_rst_product", bus.product, 32'd0);
        check("mid_rst_ctl", bus.ALUControl, 32'd0);
        @(negedge clk);
        check("mid_rst_hold_done", bus.done, 32'd0);
        rst_n = 1'b1;
        run_op(32'd6, 32'd7, -1);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 4) == 0) rb = 32'd0;
            run_op(ra, rb, $urandom_range(1, 60));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
